serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub_if.sv | 36 +++
 rtl/serial_addsub.sv | 127 ++++++++++++
 tb/tb_serial_addsub.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_if.sv
// serial_addsub_if
//   Request/response bundle for the bit-serial adder/subtractor.
//   master : drives start, op_sub, a, b; observes busy, done, result, flags.
//   slave  : the adder/subtractor itself.
//   Signals:
//     start      request to begin an operation (sampled only when idle)
//     op_sub     0 = a+b, 1 = a-b, captured with start
//     a, b       operands, captured with start
//     busy       operation in progress
//     done       one-cycle pulse, result and flags valid
//     result     registered sum / difference
//     carry_out  final carry (add) or final borrow (sub)
//     overflow   signed two's-complement overflow
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, op_sub, a, b,
        input  busy, done, result, carry_out, overflow
    );

    modport slave (
        input  start, op_sub, a, b,
        output busy, done, result, carry_out, overflow
    );
endinterface

// File: rtl/serial_addsub.sv
// serial_addsub
//   Bit-serial adder/subtractor: one operand bit pair per clock, LSB first,
//   through a single 1-bit full-adder / full-subtractor cell and a 1-bit
//   carry/borrow register.
//   Ports:
//     clk    single clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    serial_addsub_if.slave (start/op_sub/a/b in; busy/done/result/
//            carry_out/overflow out)
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold the last result
//   RUN   | shifting one bit pair per cycle through the cell
//   DONE  | one-cycle done pulse, result and flags valid
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_addsub_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_result;
    logic [CW-1:0]    r_cnt;
    logic             r_sub;
    logic             r_c;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_carry_out;
    logic             r_overflow;

    logic             w_ai;
    logic             w_bi;
    logic             w_s;
    logic             w_c_next;
    logic             w_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_sum_next;

    assign w_ai = r_a[0];
    assign w_bi = r_b[0];
    assign w_s  = w_ai ^ w_bi ^ r_c;
    assign w_c_next = r_sub ? ((~w_ai & w_bi) | (~w_ai & r_c) | (w_bi & r_c))
                            : ((w_ai & w_bi) | (r_c & (w_ai ^ w_bi)));

    // New sum bit enters at the MSB; after WIDTH shifts the first bit is at [0].
    assign w_sum_next = {w_s, r_sum[WIDTH-1:1]};

    assign w_last   = (r_state == RUN) && (r_cnt == LAST_BIT);
    assign w_accept = (r_state == IDLE) && bus.start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_result    <= '0;
            r_cnt       <= '0;
            r_sub       <= 1'b0;
            r_c         <= 1'b0;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_accept) begin
            r_a         <= bus.a;
            r_b         <= bus.b;
            r_sub       <= bus.op_sub;
            r_a_msb     <= bus.a[WIDTH-1];
            r_b_msb     <= bus.b[WIDTH-1];
            r_c         <= 1'b0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (r_state == RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_sum <= w_sum_next;
            r_c   <= w_c_next;
            r_cnt <= r_cnt + CW'(1);
            // Outputs only change on the final bit, so they stay stable
            // (cleared) for the whole run rather than showing partial sums.
            if (w_last) begin
                r_result    <= w_sum_next;
                r_carry_out <= w_c_next;
                r_overflow  <= r_sub ? ((r_a_msb != r_b_msb) && (w_s != r_a_msb))
                                     : ((r_a_msb == r_b_msb) && (w_s != r_a_msb));
            end
        end
    end

    assign bus.busy      = (r_state == RUN);
    assign bus.done      = (r_state == DONE);
    assign bus.result    = r_result;
    assign bus.carry_out = r_carry_out;
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    serial_addsub_if #(.WIDTH(8)) bus ();

    serial_addsub #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       sub;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       co;
        logic       ov;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (bus.busy && bus.done) begin
                errors++;
                $display("FAIL busy_and_done actual 1 required 0");
            end
        end
    end

    // Called at posedge+1 in an idle cycle; returns at posedge+1 in the idle
    // cycle after the done pulse. lat counts the start cycle as cycle 1.
    task automatic do_op(input logic sub, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] res, output logic co, output logic ov,
                         output int lat, output int bcnt);
        bus.start  = 1'b1;
        bus.op_sub = sub;
        bus.a      = a;
        bus.b      = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("clear_on_start", {bus.overflow, bus.carry_out, bus.result}, 0);
        lat  = 1;
        bcnt = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.done) chk("done_timeout", bus.done, 1);
        res = bus.result;
        co  = bus.carry_out;
        ov  = bus.overflow;
        @(posedge clk); #1;
        chk("done_single_cycle", bus.done, 0);
        chk("hold_result", {bus.overflow, bus.carry_out, bus.result}, {ov, co, res});
    endtask

    function automatic logic [9:0] model(input logic sub, input logic [7:0] a, input logic [7:0] b);
        int         sa, sb, s;
        logic [7:0] r;
        logic       co, ov;
        sa = $signed(a);
        sb = $signed(b);
        if (sub) begin
            r  = a - b;
            co = (a < b);
            s  = sa - sb;
        end else begin
            r  = a + b;
            co = ({1'b0, a} + {1'b0, b}) > 9'd255;
            s  = sa + sb;
        end
        ov = (s > 127) || (s < -128);
        return {ov, co, r};
    endfunction

    vec_t       vecs[10];
    logic [7:0] res;
    logic       co, ov;
    int         lat, bcnt, n, dones, last_done;
    logic [7:0] bb_a[4];
    logic [7:0] bb_b[4];
    logic       bb_s[4];
    logic [9:0] exp_m;
    logic [7:0] ra, rb;
    logic       rs;

    initial begin
        vecs[0] = '{1'b0, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vecs[9] = '{1'b1, 8'h55, 8'h55, 8'h00, 1'b0, 1'b0};

        bus.start  = 1'b0;
        bus.op_sub = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        rst_n      = 1'b0;
        #2;
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_outputs", {bus.overflow, bus.carry_out, bus.result}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].sub, vecs[i].a, vecs[i].b, res, co, ov, lat, bcnt);
            chk($sformatf("vec%0d_result", i), res, vecs[i].res);
            chk($sformatf("vec%0d_carry", i), co, vecs[i].co);
            chk($sformatf("vec%0d_overflow", i), ov, vecs[i].ov);
            chk($sformatf("vec%0d_latency", i), lat, 9);
            chk($sformatf("vec%0d_busy_cycles", i), bcnt, 8);
        end

        // start pulse mid-operation must be ignored
        bus.start = 1'b1; bus.op_sub = 1'b0; bus.a = 8'h3C; bus.b = 8'h0F;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        bus.start = 1'b1; bus.op_sub = 1'b1; bus.a = 8'h11; bus.b = 8'h22;
        @(posedge clk); #1;
        bus.start = 1'b0;
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.done) begin
                dones++;
                res = bus.result; co = bus.carry_out; ov = bus.overflow;
            end
            @(posedge clk); #1;
        end
        chk("ignore_start_dones", dones, 1);
        chk("ignore_start_result", {ov, co, res}, {2'b00, 8'h4B});

        // reset in the middle of a run
        bus.start = 1'b1; bus.op_sub = 1'b0; bus.a = 8'h3C; bus.b = 8'h0F;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("pre_reset_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_busy", bus.busy, 0);
        chk("midrun_reset_done", bus.done, 0);
        chk("midrun_reset_outputs", {bus.overflow, bus.carry_out, bus.result}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.done) dones++;
            @(posedge clk); #1;
        end
        chk("midrun_reset_no_done", dones, 0);
        do_op(1'b0, 8'h01, 8'h01, res, co, ov, lat, bcnt);
        chk("after_reset_result", {ov, co, res}, {2'b00, 8'h02});
        chk("after_reset_latency", lat, 9);

        // back-to-back with start held high
        bb_s[0] = 1'b0; bb_a[0] = 8'h12; bb_b[0] = 8'h34;
        bb_s[1] = 1'b1; bb_a[1] = 8'h10; bb_b[1] = 8'h20;
        bb_s[2] = 1'b0; bb_a[2] = 8'hC8; bb_b[2] = 8'h64;
        bb_s[3] = 1'b1; bb_a[3] = 8'h90; bb_b[3] = 8'h10;
        bus.op_sub = bb_s[0]; bus.a = bb_a[0]; bus.b = bb_b[0];
        bus.start = 1'b1;
        last_done = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!bus.done && n < 30);
            chk($sformatf("b2b%0d_done_seen", k), bus.done, 1);
            exp_m = model(bb_s[k], bb_a[k], bb_b[k]);
            chk($sformatf("b2b%0d_result", k), {bus.overflow, bus.carry_out, bus.result}, exp_m);
            if (k > 0) chk($sformatf("b2b%0d_period", k), cyc - last_done, 10);
            last_done = cyc;
            if (k < 3) begin
                bus.op_sub = bb_s[k+1]; bus.a = bb_a[k+1]; bus.b = bb_b[k+1];
            end else begin
                bus.start = 1'b0;
            end
        end
        @(posedge clk); #1;

        // random ops against an arithmetic model
        for (int k = 0; k < 1000; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            exp_m = model(rs, ra, rb);
            do_op(rs, ra, rb, res, co, ov, lat, bcnt);
            chk("random_op", {ov, co, res}, exp_m);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
